// File: rtl/string_move_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : string_move_unit_pkg
// Brief    : Shared state encoding and step constants for the string mover.
// Revision : 1.0 - initial release
// ============================================================================
package string_move_unit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } smu_state_t;

    localparam int STEP_BYTE = 1;
    localparam int STEP_WORD = 2;

endpackage
`default_nettype wire

// File: rtl/string_move_unit_index_stepper.sv
`default_nettype none
// ============================================================================
// Module   : index_stepper
// Brief    : Combinational +/- element-size step of an index, modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module index_stepper
    import string_move_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dec,
    input  logic             i_word,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] w_step;

    assign w_step  = i_word ? WIDTH'(STEP_WORD) : WIDTH'(STEP_BYTE);
    assign o_value = i_dec ? (i_value - w_step) : (i_value + w_step);

endmodule
`default_nettype wire

// File: rtl/string_move_unit.sv
`default_nettype none
// ============================================================================
// Module   : string_move_unit
// Brief    : REP MOVS sequencer: read at SI, write at DI, step indexes, count CX.
// Revision : 1.0 - initial release
// ============================================================================
module string_move_unit
    import string_move_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             rep,
    input  logic             df,
    input  logic             word,
    input  logic             intr,
    input  logic [WIDTH-1:0] si_in,
    input  logic [WIDTH-1:0] di_in,
    input  logic [WIDTH-1:0] cx_in,
    output logic [WIDTH-1:0] si_out,
    output logic [WIDTH-1:0] di_out,
    output logic [WIDTH-1:0] cx_out,
    output logic             si_we,
    output logic             di_we,
    output logic             cx_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_byte,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done
);

    smu_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_si, r_di, r_cx, r_data;
    logic [WIDTH-1:0] w_si_nxt, w_di_nxt, w_cx_nxt, w_data_nxt;
    logic             r_df, r_word, r_rep;
    logic             w_df_nxt, w_word_nxt, w_rep_nxt;
    logic [WIDTH-1:0] w_si_step, w_di_step, w_cap;

    logic [WIDTH-1:0] w_si_out_nxt, w_di_out_nxt, w_cx_out_nxt;
    logic [WIDTH-1:0] w_addr_nxt, w_wdata_nxt;
    logic             w_si_we_nxt, w_di_we_nxt, w_cx_we_nxt;
    logic             w_req_nxt, w_we_nxt, w_byte_nxt, w_busy_nxt, w_done_nxt;

    index_stepper #(.WIDTH(WIDTH)) u_si_step (
        .i_value (r_si),
        .i_dec   (r_df),
        .i_word  (r_word),
        .o_value (w_si_step)
    );

    index_stepper #(.WIDTH(WIDTH)) u_di_step (
        .i_value (r_di),
        .i_dec   (r_df),
        .i_word  (r_word),
        .o_value (w_di_step)
    );

    assign w_cap = r_word ? mem_rdata : {{(WIDTH-8){1'b0}}, mem_rdata[7:0]};

    // Every output is computed one cycle ahead and registered, so the
    // steppers run during the WRITE ack cycle and the results appear in UPDATE.
    always_comb begin
        w_state_nxt  = r_state;
        w_si_nxt     = r_si;
        w_di_nxt     = r_di;
        w_cx_nxt     = r_cx;
        w_data_nxt   = r_data;
        w_df_nxt     = r_df;
        w_word_nxt   = r_word;
        w_rep_nxt    = r_rep;
        w_si_out_nxt = si_out;
        w_di_out_nxt = di_out;
        w_cx_out_nxt = cx_out;
        w_si_we_nxt  = 1'b0;
        w_di_we_nxt  = 1'b0;
        w_cx_we_nxt  = 1'b0;
        w_req_nxt    = mem_req;
        w_we_nxt     = mem_we;
        w_byte_nxt   = mem_byte;
        w_addr_nxt   = mem_addr;
        w_wdata_nxt  = mem_wdata;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_si_nxt   = si_in;
                    w_di_nxt   = di_in;
                    w_cx_nxt   = cx_in;
                    w_df_nxt   = df;
                    w_word_nxt = word;
                    w_rep_nxt  = rep;
                    if (rep && (cx_in == '0)) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = READ;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_byte_nxt  = ~word;
                        w_addr_nxt  = si_in;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    w_data_nxt  = w_cap;
                    w_state_nxt = WRITE;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_di;
                    w_wdata_nxt = w_cap;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    w_state_nxt  = UPDATE;
                    w_req_nxt    = 1'b0;
                    w_we_nxt     = 1'b0;
                    w_si_nxt     = w_si_step;
                    w_di_nxt     = w_di_step;
                    w_si_out_nxt = w_si_step;
                    w_di_out_nxt = w_di_step;
                    w_si_we_nxt  = 1'b1;
                    w_di_we_nxt  = 1'b1;
                    if (r_rep) begin
                        w_cx_nxt     = r_cx - 1'b1;
                        w_cx_out_nxt = r_cx - 1'b1;
                        w_cx_we_nxt  = 1'b1;
                    end
                end
            end
            UPDATE: begin
                // r_cx already holds the decremented count here
                if (r_rep && (r_cx != '0) && !intr) begin
                    w_state_nxt = READ;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_addr_nxt  = r_si;
                end else begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_si      <= '0;
            r_di      <= '0;
            r_cx      <= '0;
            r_data    <= '0;
            r_df      <= 1'b0;
            r_word    <= 1'b0;
            r_rep     <= 1'b0;
            si_out    <= '0;
            di_out    <= '0;
            cx_out    <= '0;
            si_we     <= 1'b0;
            di_we     <= 1'b0;
            cx_we     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_si      <= w_si_nxt;
            r_di      <= w_di_nxt;
            r_cx      <= w_cx_nxt;
            r_data    <= w_data_nxt;
            r_df      <= w_df_nxt;
            r_word    <= w_word_nxt;
            r_rep     <= w_rep_nxt;
            si_out    <= w_si_out_nxt;
            di_out    <= w_di_out_nxt;
            cx_out    <= w_cx_out_nxt;
            si_we     <= w_si_we_nxt;
            di_we     <= w_di_we_nxt;
            cx_we     <= w_cx_we_nxt;
            mem_req   <= w_req_nxt;
            mem_we    <= w_we_nxt;
            mem_byte  <= w_byte_nxt;
            mem_addr  <= w_addr_nxt;
            mem_wdata <= w_wdata_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_string_move_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_string_move_unit
// Brief    : Table-driven and randomized bench for string_move_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_string_move_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, rep = 1'b0, df = 1'b0, word = 1'b0, intr = 1'b0;
    logic [15:0] si_in = '0, di_in = '0, cx_in = '0;
    logic [15:0] si_out, di_out, cx_out, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        si_we, di_we, cx_we, mem_req, mem_we, mem_byte, busy, done;
    logic        mem_ack = 1'b0;

    string_move_unit #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .rep(rep), .df(df), .word(word), .intr(intr),
        .si_in(si_in), .di_in(di_in), .cx_in(cx_in),
        .si_out(si_out), .di_out(di_out), .cx_out(cx_out),
        .si_we(si_we), .di_we(di_we), .cx_we(cx_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rep, df, word;
        logic [15:0] si, di, cx;
        int          waits, intr_elem;
        logic        fix_en;
        logic [15:0] fix;
        logic        start_in_done;
        int          exp_n;
        logic [15:0] exp_si, exp_di, exp_cx;
    } vec_t;

    int pass_cnt = 0, check_cnt = 0;

    // stimulus controls shared with the memory responder
    int          wait_cycles = 0, intr_elem = 0, elem_base = 0;
    logic        noise_en = 1'b0, fix_en = 1'b0;
    logic [15:0] fix_data = '0;

    // monitor state (written only by the responder process)
    int          wcnt = 0, done_cnt = 0, si_we_cnt = 0, di_we_cnt = 0, cx_we_cnt = 0;
    int          req_cnt = 0, stab_err = 0;
    logic [15:0] last_si = '0, last_di = '0, last_cx = '0;
    logic [33:0] ph = '0;
    logic [33:0] txn_q[$];

    function automatic logic [15:0] rd_value(input logic [15:0] a);
        logic [31:0] t;
        t = {16'h0, a} * 32'h9E37;
        return fix_en ? fix_data : (t[15:0] ^ 16'h5A5A ^ {a[7:0], a[15:8]});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Memory responder with programmable wait states, plus output monitor
    always @(negedge CLK) begin
        if (done)  done_cnt++;
        if (si_we) begin si_we_cnt++; last_si = si_out; end
        if (di_we) begin di_we_cnt++; last_di = di_out; end
        if (cx_we) begin cx_we_cnt++; last_cx = cx_out; end
        if (mem_req) begin
            req_cnt++;
            if (wcnt != 0 && {mem_we, mem_byte, mem_addr, mem_wdata} != ph) stab_err++;
            if (wcnt == 0) ph = {mem_we, mem_byte, mem_addr, mem_wdata};
            if (wcnt == wait_cycles) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_value(mem_addr);
                txn_q.push_back({mem_we, mem_byte, mem_addr, mem_wdata});
                wcnt = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wcnt++;
            end
        end else begin
            wcnt      = 0;
            mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 16'($urandom);
        end
        if (si_we && intr_elem != 0 && (si_we_cnt - elem_base) == intr_elem) intr = 1'b1;
        else if (si_we) intr = 1'b0;
        else intr = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic run(input vec_t v, input bit use_table);
        int n, step, cyc, base_si, base_di, base_cx, base_done, base_txn, base_req, base_stab;
        logic [15:0] off, ra, wa, rd, exp_si, exp_di, exp_cx;
        logic [33:0] t;
        bit got, busy_seen;

        // reference model: element count, final registers
        step = v.word ? 2 : 1;
        if (!v.rep) n = 1;
        else if (v.cx == 0) n = 0;
        else if (v.intr_elem != 0 && v.intr_elem < int'(v.cx)) n = v.intr_elem;
        else n = int'(v.cx);
        off    = 16'(n * step);
        exp_si = v.df ? v.si - off : v.si + off;
        exp_di = v.df ? v.di - off : v.di + off;
        exp_cx = v.cx - 16'(n);
        if (use_table) begin
            chk("table_n", n, v.exp_n);
            exp_si = v.exp_si; exp_di = v.exp_di; exp_cx = v.exp_cx;
        end

        @(posedge CLK); #1;
        wait_cycles = v.waits; intr_elem = v.intr_elem; fix_en = v.fix_en; fix_data = v.fix;
        elem_base = si_we_cnt;
        base_si = si_we_cnt; base_di = di_we_cnt; base_cx = cx_we_cnt; base_done = done_cnt;
        base_txn = txn_q.size(); base_req = req_cnt; base_stab = stab_err;
        start = 1'b1; rep = v.rep; df = v.df; word = v.word;
        si_in = v.si; di_in = v.di; cx_in = v.cx;
        @(posedge CLK); #1;
        start = 1'b0;
        si_in = 16'($urandom); di_in = 16'($urandom); cx_in = 16'($urandom);
        rep = 1'($urandom); df = 1'($urandom); word = 1'($urandom);

        cyc = 0; got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) chk("busy_rise", busy, 1'b1);
            if (done) got = 1;
        end
        chk("done_seen", got, 1'b1);
        chk("latency", cyc, (n == 0) ? 1 : n * (2 * v.waits + 3) + 1);
        if (v.start_in_done) begin
            start = 1'b1; rep = 1'b0; cx_in = 16'h0005;
        end
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                start = 1'b0;
                chk("done_pulse", done, 1'b0);
            end
            busy_seen |= busy;
        end
        chk("busy_fall", busy_seen, 1'b0);
        chk("done_cnt", done_cnt - base_done, 1);
        chk("si_we_cnt", si_we_cnt - base_si, n);
        chk("di_we_cnt", di_we_cnt - base_di, n);
        chk("cx_we_cnt", cx_we_cnt - base_cx, v.rep ? n : 0);
        if (n > 0) begin
            chk("si_out", last_si, exp_si);
            chk("di_out", last_di, exp_di);
            if (v.rep) chk("cx_out", last_cx, exp_cx);
        end
        if (n == 0) chk("no_req", req_cnt - base_req, 0);
        chk("txn_cnt", txn_q.size() - base_txn, 2 * n);
        chk("addr_stable", stab_err - base_stab, 0);
        if (txn_q.size() - base_txn == 2 * n) begin
            for (int e = 0; e < n; e++) begin
                off = 16'(e * step);
                ra  = v.df ? v.si - off : v.si + off;
                wa  = v.df ? v.di - off : v.di + off;
                rd  = rd_value(ra);
                if (!v.word) rd = {8'h00, rd[7:0]};
                t = txn_q[base_txn + 2 * e];
                chk("read_txn", {t[33:32], t[31:16]}, {1'b0, ~v.word, ra});
                t = txn_q[base_txn + 2 * e + 1];
                chk("write_txn", t, {1'b1, ~v.word, wa, rd});
            end
        end
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        //            rep  df   word si        di        cx       w  ie fx   fix        sid  n  e_si      e_di      e_cx
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0200, 16'h1234, 0, 0, 1'b1, 16'hAB5A, 1'b1, 1, 16'h0101, 16'h0201, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'h1000, 16'h2000, 16'h0003, 0, 0, 1'b0, 16'h0000, 1'b0, 3, 16'h0FFA, 16'h1FFA, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0, 1, 16'h0001, 16'h0002, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0300, 16'h0400, 16'h0005, 4, 1, 1'b0, 16'h0000, 1'b0, 1, 16'h0301, 16'h0401, 16'h0004};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h8000, 16'h0000, 1, 0, 1'b0, 16'h0000, 1'b0, 1, 16'hFFFF, 16'h7FFF, 16'h0000};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000, 0, 0, 1'b0, 16'h0000, 1'b0, 1, 16'hFFFE, 16'hFFFF, 16'h0000};

        repeat (2) @(negedge CLK);
        chk("rst_outs", {si_out, di_out, cx_out, si_we, di_we, cx_we, mem_req, mem_we, mem_byte, busy, done}, '0);
        chk("rst_mem", {mem_addr, mem_wdata}, '0);
        RST = 1'b0;

        for (int k = 0; k < 7; k++) run(tbl[k], 1'b1);

        // reset while a write is outstanding
        @(posedge CLK); #1;
        wait_cycles = 3; intr_elem = 0; fix_en = 1'b0;
        start = 1'b1; rep = 1'b1; df = 1'b0; word = 1'b1;
        si_in = 16'h4000; di_in = 16'h5000; cx_in = 16'h0005;
        @(posedge CLK); #1;
        start = 1'b0;
        begin
            bit hit;
            int base_we;
            hit = 0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge CLK);
                if (mem_req && mem_we) hit = 1;
            end
            chk("reach_write", hit, 1'b1);
            base_we = si_we_cnt + di_we_cnt + cx_we_cnt;
            #2 RST = 1'b1;
            #1;
            chk("rst_req_drop", {mem_req, mem_we, busy, si_we, di_we, cx_we, done}, '0);
            repeat (2) @(negedge CLK);
            RST = 1'b0;
            chk("rst_no_we", si_we_cnt + di_we_cnt + cx_we_cnt - base_we, 0);
        end
        run(tbl[1], 1'b1);

        // randomized transfers against the reference model
        noise_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rv.rep  = 1'($urandom);
            rv.df   = 1'($urandom);
            rv.word = 1'($urandom);
            rv.si   = 16'($urandom);
            rv.di   = 16'($urandom);
            rv.cx   = 16'($urandom_range(0, 6));
            rv.waits = $urandom_range(0, 2);
            rv.intr_elem = $urandom_range(0, 6);
            rv.fix_en = 1'b0; rv.fix = '0;
            rv.start_in_done = 1'($urandom);
            rv.exp_n = 0; rv.exp_si = '0; rv.exp_di = '0; rv.exp_cx = '0;
            run(rv, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
